// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: issues one data-memory transaction per load/store over a
// req/gnt/rvalid bus and returns the formatted load word to the WB register.
module lsu_mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       st_data_i,
    output logic              stall_o,
    output logic              done_o,
    output logic              fault_o,
    output logic [31:0]       ld_data_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t     state;
    logic [1:0] lane;
    logic [2:0] f3;
    logic       op;
    logic       legal;
    logic       misal;
    logic       bad;

    function automatic logic [3:0] byte_en(input logic [2:0] fn, input logic [1:0] ln);
        case (fn[1:0])
            2'b00:   byte_en = 4'b0001 << ln;
            2'b01:   byte_en = 4'b0011 << ln;
            default: byte_en = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] fn, input logic [31:0] d);
        case (fn[1:0])
            2'b00:   store_lanes = {4{d[7:0]}};
            2'b01:   store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [2:0] fn, input logic [1:0] ln,
                                                input logic [31:0] w);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = w >> {ln, 3'b000};
        b       = shifted[7:0];
        h       = ln[1] ? w[31:16] : w[15:0];
        case (fn)
            3'b000:  load_format = {{24{b[7]}}, b};
            3'b100:  load_format = {24'd0, b};
            3'b001:  load_format = {{16{h[15]}}, h};
            3'b101:  load_format = {16'd0, h};
            default: load_format = w;
        endcase
    endfunction

    // Unsigned widths exist only for loads; misalignment is judged on the size bits alone.
    always_comb begin
        op = mem_rd_i | mem_wr_i;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !mem_wr_i;
            default:                legal = 1'b0;
        endcase
        misal = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        bad     = !legal || misal;
        fault_o = (state == IDLE) && op && bad;
        stall_o = (state == REQ) || (state == WAIT) || ((state == IDLE) && op && !bad);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= 4'h0;
            dmem_wdata_o <= 32'd0;
            done_o       <= 1'b0;
            ld_data_o    <= 32'd0;
            lane         <= 2'b00;
            f3           <= 3'b000;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (op && !bad) begin
                        state        <= REQ;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= mem_wr_i;
                        dmem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                        dmem_be_o    <= byte_en(funct3_i, addr_i[1:0]);
                        dmem_wdata_o <= store_lanes(funct3_i, st_data_i);
                        lane         <= addr_i[1:0];
                        f3           <= funct3_i;
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        if (dmem_we_o) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        ld_data_o <= load_format(f3, lane, dmem_rdata_i);
                        state     <= DONE;
                        done_o    <= 1'b1;
                    end
                end
                // One non-stalling cycle lets the pipe advance before a new op is accepted.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a memory responder and an expected-load scoreboard.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    logic        stall, done, fault;
    logic [31:0] ld_data;
    logic        req, we;
    logic [31:0] daddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem[int];
    int          gnt_delay = 0;
    int          rv_delay = 1;
    int          grants = 0;
    int          wcnt = 0;
    int          rcnt = 0;
    logic [31:0] raddr = 32'd0;
    logic [31:0] wr_word;
    int          g0;
    int          st, dc;
    logic [3:0]  be0;
    logic [31:0] wd0, ad0;

    lsu_mem_stage #(.ADDR_W(32)) dut (
        .clk_i(clk), .reset_i(reset), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
        .funct3_i(funct3), .addr_i(addr), .st_data_i(st_data),
        .stall_o(stall), .done_o(done), .fault_o(fault), .ld_data_o(ld_data),
        .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(daddr), .dmem_be_o(be),
        .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
        .dmem_rdata_i(rdata)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Memory responder: grant after gnt_delay request cycles, read data rv_delay cycles later.
    initial forever begin
        @(posedge clk);
        #2;
        gnt = 1'b0;
        rvalid = 1'b0;
        if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
                rvalid = 1'b1;
                rdata = mem.exists(int'(raddr >> 2)) ? mem[int'(raddr >> 2)] : 32'd0;
            end
        end
        if (req && !reset) begin
            if (wcnt == gnt_delay) begin
                gnt = 1'b1;
                wcnt = 0;
                grants++;
                if (we) begin
                    wr_word = mem.exists(int'(daddr >> 2)) ? mem[int'(daddr >> 2)] : 32'd0;
                    for (int i = 0; i < 4; i++)
                        if (be[i]) wr_word[i*8 +: 8] = wdata[i*8 +: 8];
                    mem[int'(daddr >> 2)] = wr_word;
                end else begin
                    raddr = daddr;
                    rcnt = rv_delay;
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Presents one memory op, follows it to done_o, then lets the pipe advance one cycle.
    task automatic do_op(input string tag, input logic rd, input logic wr, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_ld,
                         input int exp_stalls, input int exp_reqs,
                         output int stalls, output int done_cyc,
                         output logic [3:0] be_f, output logic [31:0] wd_f, output logic [31:0] ad_f);
        int          reqs;
        int          unstable;
        logic        we_f;
        logic [31:0] ld_at_done;
        logic [31:0] e;
        mem_rd = rd;
        mem_wr = wr;
        funct3 = fn;
        addr = a;
        st_data = d;
        exp_q.push_back(exp_ld);
        stalls = 0;
        reqs = 0;
        unstable = 0;
        done_cyc = -1;
        be_f = 4'h0;
        wd_f = 32'd0;
        ad_f = 32'd0;
        we_f = 1'b0;
        ld_at_done = 32'd0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (req) begin
                if (reqs == 0) begin
                    be_f = be; wd_f = wdata; ad_f = daddr; we_f = we;
                end else if ({be, wdata, daddr, we} !== {be_f, wd_f, ad_f, we_f}) begin
                    unstable++;
                end
                reqs++;
            end
            if (done) begin
                done_cyc = c;
                ld_at_done = ld_data;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "_ld"}, ld_at_done, e);
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_stalls));
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        check({tag, "_reqs"}, 32'(reqs), 32'(exp_reqs));
        check({tag, "_req_stable"}, 32'(unstable), 32'd0);
        check({tag, "_we"}, 32'(we_f), 32'(wr));
    endtask

    task automatic go_idle();
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        funct3 = 3'b000;
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem[int'(32'h1000 >> 2)] = 32'h80FF0000;
        mem[0] = 32'h80010000;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(req), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_be", 32'(be), 32'd0);
        check("rst_addr", daddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_ld", ld_data, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Byte loads, back to back
        do_op("lb", 1'b1, 1'b0, 3'b000, 32'h1003, 32'd0, 32'hFFFFFF80, 3, 1, st, dc, be0, wd0, ad0);
        do_op("lbu", 1'b1, 1'b0, 3'b100, 32'h1003, 32'd0, 32'h00000080, 3, 1, st, dc, be0, wd0, ad0);
        go_idle();

        // Halfword loads
        do_op("lh", 1'b1, 1'b0, 3'b001, 32'h0002, 32'd0, 32'hFFFF8001, 3, 1, st, dc, be0, wd0, ad0);
        do_op("lhu", 1'b1, 1'b0, 3'b101, 32'h0002, 32'd0, 32'h00008001, 3, 1, st, dc, be0, wd0, ad0);
        go_idle();

        // Non-memory instruction passes straight through
        addr = 32'h0000_1234;
        #1;
        check("nonmem_stall", 32'(stall), 32'd0);
        @(negedge clk);
        check("nonmem_req", 32'(req), 32'd0);
        @(posedge clk);
        #1;

        // Halfword store with a late grant; ld_data holds across it
        gnt_delay = 2;
        do_op("sh", 1'b0, 1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 32'h00008001, 4, 3, st, dc, be0, wd0, ad0);
        check("sh_be", 32'(be0), 32'h0000000C);
        check("sh_wdata", wd0, 32'hABCDABCD);
        check("sh_addr", ad0, 32'h00002000);
        gnt_delay = 0;
        go_idle();
        do_op("lw_after_sh", 1'b1, 1'b0, 3'b010, 32'h2000, 32'd0, 32'hABCD0000, 3, 1, st, dc, be0, wd0, ad0);
        go_idle();

        // Faults: misaligned word, illegal load funct3, unsigned store
        g0 = grants;
        mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h2001;
        #1;
        check("lw_mis_fault", 32'(fault), 32'd1);
        check("lw_mis_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        check("lw_mis_req", 32'(req), 32'd0);
        funct3 = 3'b011; addr = 32'h40;
        #1;
        check("ld011_fault", 32'(fault), 32'd1);
        check("ld011_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        check("ld011_req", 32'(req), 32'd0);
        mem_rd = 1'b0; mem_wr = 1'b1; funct3 = 3'b100;
        #1;
        check("sbu_fault", 32'(fault), 32'd1);
        @(posedge clk);
        #1;
        check("sbu_req", 32'(req), 32'd0);
        go_idle();
        check("fault_clear", 32'(fault), 32'd0);
        check("fault_no_grants", 32'(grants - g0), 32'd0);

        // Store then load of the same word with the pipe advancing on !stall
        g0 = grants;
        do_op("sw", 1'b0, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'hABCD0000, 2, 1, st, dc, be0, wd0, ad0);
        check("sw_be", 32'(be0), 32'h0000000F);
        do_op("lw", 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 32'hDEADBEEF, 3, 1, st, dc, be0, wd0, ad0);
        go_idle();
        check("sw_lw_grants", 32'(grants - g0), 32'd2);
        do_op("sb", 1'b0, 1'b1, 3'b000, 32'h41, 32'h000000A5, 32'hDEADBEEF, 2, 1, st, dc, be0, wd0, ad0);
        check("sb_be", 32'(be0), 32'h00000002);
        check("sb_wdata", wd0, 32'hA5A5A5A5);
        do_op("lb41", 1'b1, 1'b0, 3'b000, 32'h41, 32'd0, 32'hFFFFFFA5, 3, 1, st, dc, be0, wd0, ad0);
        do_op("lw_after_sb", 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 32'hDEADA5EF, 3, 1, st, dc, be0, wd0, ad0);
        go_idle();

        // Reset while waiting for read data; the late rvalid must be ignored
        rv_delay = 2;
        mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h40;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("wait_stall", 32'(stall), 32'd1);
        check("wait_req", 32'(req), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_rd = 1'b0;
        #1;
        check("rstwait_req", 32'(req), 32'd0);
        check("rstwait_ld", ld_data, 32'd0);
        check("rstwait_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("late_rvalid_done", 32'(done), 32'd0);
        check("late_rvalid_ld", ld_data, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("late_rvalid_done2", 32'(done), 32'd0);
        check("late_rvalid_req", 32'(req), 32'd0);
        check("late_rvalid_stall", 32'(stall), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
